// File: rtl/branch_pc_unit_pkg.sv
// Shared head package for the fetch/branch front end: fetch FSM states,
// redirect kinds, the default reset PC and the D-stage comparator opcodes.
package branch_pc_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // Fetch FSM: REQ issues pc, WAIT holds the address until ack,
  // HOLD parks a fetched instruction while D is stalled.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Kind of control transfer requested by the D-stage instruction.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_BR   = 2'd1,
    RD_J    = 2'd2,
    RD_JR   = 2'd3
  } redirect_e;

  // Opcodes understood by the D-stage branch comparator.
  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LEZ = 3'd4,
    CMP_GTZ = 3'd5
  } cmp_op_e;

  // A fetch address is legal only on a word boundary.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/branch_pc_unit_npc_calc.sv
// Combinational redirect target calculation for the D-stage instruction.
module npc_calc
  import branch_pc_unit_pkg::*;
(
  input  logic [31:0] d_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] jr_target,
  input  logic        br_en,
  input  logic        cmp_cond,
  input  logic        j_en,
  input  logic        jr_en,
  output logic [31:0] target,
  output redirect_e   rtype
);

  logic [31:0] w_br_target;
  logic [31:0] w_j_target;

  // Pick the redirect kind and target, jr beating j beating a taken branch.
  always_comb begin
    w_br_target = d_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    w_j_target  = {d_pc[31:28], index26, 2'b00};
    rtype       = RD_NONE;
    target      = w_br_target;
    if (jr_en) begin
      rtype  = RD_JR;
      target = jr_target;
    end else if (j_en) begin
      rtype  = RD_J;
      target = w_j_target;
    end else if (br_en && cmp_cond) begin
      rtype  = RD_BR;
      target = w_br_target;
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Fetch PC sequencer: drives instruction memory, hands instructions to the
// F/D register and applies branch/jump redirects after the delay slot.
module branch_pc_unit
  import branch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_en,
  input  logic        cmp_cond,
  input  logic        j_en,
  input  logic        jr_en,
  input  logic [31:0] d_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] f_pc,
  output logic        f_valid,
  output logic        adel
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic         r_pend_valid;
  logic [31:0]  r_pend_target;

  logic [31:0]  w_target;
  redirect_e    w_rtype;
  logic         w_redirect;
  logic         w_deliver;
  logic [31:0]  w_next_pc;

  npc_calc u_npc_calc (
    .d_pc      (d_pc),
    .imm16     (imm16),
    .index26   (index26),
    .jr_target (jr_target),
    .br_en     (br_en),
    .cmp_cond  (cmp_cond),
    .j_en      (j_en),
    .jr_en     (jr_en),
    .target    (w_target),
    .rtype     (w_rtype)
  );

  // Next-state, fetch request and delivery decode; all quiet while reset is held.
  always_comb begin
    w_next_state = r_state;
    w_deliver    = 1'b0;
    imem_req     = 1'b0;
    w_redirect   = reset && !stall && (w_rtype != RD_NONE);
    if (reset) begin
      unique case (r_state)
        ST_REQ, ST_WAIT: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            if (!stall) begin
              w_deliver    = 1'b1;
              w_next_state = ST_REQ;
            end else begin
              w_next_state = ST_HOLD;
            end
          end else begin
            w_next_state = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            w_deliver    = 1'b1;
            w_next_state = ST_REQ;
          end
        end
        default: w_next_state = ST_REQ;
      endcase
    end
    if (w_redirect) begin
      w_next_pc = w_target;
    end else if (r_pend_valid) begin
      w_next_pc = r_pend_target;
    end else begin
      w_next_pc = r_pc + 32'd4;
    end
  end

  // State, PC and one-entry pending-redirect registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_REQ;
      r_pc          <= RESET_PC;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_deliver) begin
        r_pc         <= w_next_pc;
        r_pend_valid <= 1'b0;
      end else if (w_redirect) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_target;
      end
    end
  end

  assign imem_addr = r_pc;
  assign f_pc      = r_pc;
  assign f_valid   = w_deliver;
  assign adel      = ALIGN_CHECK && w_redirect && is_misaligned(w_target);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios plus a random
// run compared against a behavioural fetch model.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_en, cmp_cond, j_en, jr_en, imem_ack;
  logic [31:0] d_pc, jr_target;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic        imem_req, f_valid, adel;
  logic [31:0] imem_addr, f_pc;

  int checks = 0;
  int errors = 0;

  // Behavioural model: fetch pc, pending redirect, parked instruction.
  logic [31:0] mPc;
  bit          mPendValid;
  logic [31:0] mPendTarget;
  bit          mParked;

  branch_pc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_en     (br_en),
    .cmp_cond  (cmp_cond),
    .j_en      (j_en),
    .jr_en     (jr_en),
    .d_pc      (d_pc),
    .imm16     (imm16),
    .index26   (index26),
    .jr_target (jr_target),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .f_pc      (f_pc),
    .f_valid   (f_valid),
    .adel      (adel)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive(input bit st, input bit ack, input bit br, input bit cc,
                       input bit j, input bit jr, input logic [31:0] dpc,
                       input logic [15:0] imm, input logic [25:0] idx,
                       input logic [31:0] jrt);
    stall = st; imem_ack = ack; br_en = br; cmp_cond = cc; j_en = j; jr_en = jr;
    d_pc = dpc; imm16 = imm; index26 = idx; jr_target = jrt;
  endtask

  task automatic model_reset();
    mPc = 32'h0000_3000; mPendValid = 0; mPendTarget = '0; mParked = 0;
  endtask

  // Redirect target straight from the instruction-set rules.
  function automatic void model_target(output bit taken, output logic [31:0] tgt);
    logic signed [31:0] off;
    taken = jr_en || j_en || (br_en && cmp_cond);
    off   = $signed(imm16);
    off   = off * 4;
    if (jr_en)     tgt = jr_target;
    else if (j_en) tgt = (d_pc & 32'hF000_0000) + ({6'b0, index26} * 32'd4);
    else           tgt = d_pc + 32'd4 + off;
  endfunction

  function automatic bit model_deliver();
    return reset && !stall && (mParked || imem_ack);
  endfunction

  // Advance the model by one clock using the inputs now applied, then move to the next negedge.
  task automatic advance();
    bit          tk;
    logic [31:0] tg;
    if (!reset) begin
      model_reset();
    end else begin
      model_target(tk, tg);
      tk = tk && !stall;
      if (model_deliver()) begin
        mPc        = tk ? tg : (mPendValid ? mPendTarget : mPc + 32'd4);
        mPendValid = 0;
        mParked    = 0;
      end else begin
        if (tk) begin mPendValid = 1; mPendTarget = tg; end
        if (imem_ack && stall && !mParked) mParked = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1, 0, 0, 1, 0, 32'h3000, 16'h0, 26'h40, 32'h0);
    model_reset();
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b required 0", imem_req); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fvalid: got %b required 0", f_valid); end
    checks++; if (adel !== 1'b0) begin errors++; $display("[TB] FAIL reset_adel: got %b required 0", adel); end
    checks++; if (f_pc !== 32'h3000) begin errors++; $display("[TB] FAIL reset_fpc: got %h required 00003000", f_pc); end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL release_req: got %b required 1", imem_req); end
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("[TB] FAIL release_addr: got %h required 00003000", imem_addr); end
    advance();
  endtask

  task automatic test_sequential();
    logic [31:0] expAddr;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      expAddr = 32'h3000 + 32'(4 * i);
      drive(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
      #1;
      checks++; if (imem_addr !== expAddr) begin errors++; $display("[TB] FAIL seq_addr%0d: got %h required %h", i, imem_addr, expAddr); end
      checks++; if (f_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_fvalid%0d: got %b required 1", i, f_valid); end
      advance();
    end
  endtask

  task automatic test_branch(input bit taken);
    logic [31:0] expNext;
    expNext = taken ? 32'h3010 : 32'h3008;
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    advance();
    drive(0, 1, 1, taken, 0, 0, 32'h3000, 16'h0003, 26'h0, 32'h0);
    #1;
    checks++; if (f_pc !== 32'h3004 || f_valid !== 1'b1) begin errors++; $display("[TB] FAIL br%0d_slot: got %h/%b required 00003004/1", taken, f_pc, f_valid); end
    checks++; if (adel !== 1'b0) begin errors++; $display("[TB] FAIL br%0d_adel: got %b required 0", taken, adel); end
    advance();
    drive(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    #1;
    checks++; if (imem_addr !== expNext) begin errors++; $display("[TB] FAIL br%0d_next: got %h required %h", taken, imem_addr, expNext); end
    advance();
  endtask

  task automatic test_wait_pending();
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    advance();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(0, 0, 0, 0, 1, 0, 32'h3000, 16'h0, 26'h0000C40, 32'h0);
      else        drive(0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
      #1;
      checks++; if (imem_addr !== 32'h3004 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL wait_addr%0d: got %h/%b required 00003004/1", i, imem_addr, imem_req); end
      checks++; if (f_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_fvalid%0d: got %b required 0", i, f_valid); end
      advance();
    end
    drive(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    #1;
    checks++; if (f_valid !== 1'b1 || f_pc !== 32'h3004) begin errors++; $display("[TB] FAIL wait_deliver: got %b/%h required 1/00003004", f_valid, f_pc); end
    advance();
    #1;
    checks++; if (imem_addr !== 32'h3100) begin errors++; $display("[TB] FAIL wait_jump: got %h required 00003100", imem_addr); end
    advance();
  endtask

  task automatic test_back_to_back();
    // Two redirects while waiting: the later one wins; stalled redirect is ignored.
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    advance();
    drive(0, 0, 0, 0, 1, 0, 32'h3000, 16'h0, 26'h0000C40, 32'h0);
    advance();
    drive(0, 0, 0, 0, 0, 1, 32'h3000, 16'h0, 26'h0, 32'h0000_5000);
    advance();
    drive(1, 0, 0, 0, 1, 0, 32'h3000, 16'h0, 26'h0000800, 32'h0);
    advance();
    drive(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    advance();
    #1;
    checks++; if (imem_addr !== 32'h5000) begin errors++; $display("[TB] FAIL overwrite_next: got %h required 00005000", imem_addr); end
    advance();
  endtask

  task automatic test_stall_hold();
    do_reset();
    drive(1, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    #1;
    checks++; if (f_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_ack_fvalid: got %b required 0", f_valid); end
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
      #1;
      checks++; if (f_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_stalled%0d: got %b/%b required 0/0", i, f_valid, imem_req); end
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    #1;
    checks++; if (f_valid !== 1'b1 || f_pc !== 32'h3000) begin errors++; $display("[TB] FAIL hold_release: got %b/%h required 1/00003000", f_valid, f_pc); end
    advance();
    #1;
    checks++; if (f_valid !== 1'b0 || imem_addr !== 32'h3004 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL hold_after: got %b/%h/%b required 0/00003004/1", f_valid, imem_addr, imem_req); end
    advance();
  endtask

  task automatic test_jr_misaligned();
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    advance();
    drive(0, 1, 0, 0, 0, 1, 32'h3000, 16'h0, 26'h0, 32'h0000_3002);
    #1;
    checks++; if (adel !== 1'b1) begin errors++; $display("[TB] FAIL jr_adel: got %b required 1", adel); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    #1;
    checks++; if (adel !== 1'b0) begin errors++; $display("[TB] FAIL jr_adel_pulse: got %b required 0", adel); end
    checks++; if (imem_addr !== 32'h3002) begin errors++; $display("[TB] FAIL jr_next: got %h required 00003002", imem_addr); end
    advance();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    advance();
    drive(0, 1, 0, 0, 0, 1, 32'h3000, 16'h0, 26'h0, 32'hFFFF_FFFC);
    advance();
    drive(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    #1;
    checks++; if (f_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_top: got %h required fffffffc", f_pc); end
    advance();
    #1;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_zero: got %h required 00000000", imem_addr); end
    advance();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    advance();
    #1;
    checks++; if (imem_addr !== 32'h3004) begin errors++; $display("[TB] FAIL midwait_addr: got %h required 00003004", imem_addr); end
    #2;
    reset    = 1'b0;
    imem_ack = 1'b1;
    model_reset();
    #1;
    checks++; if (imem_req !== 1'b0 || f_valid !== 1'b0) begin errors++; $display("[TB] FAIL midwait_reset: got %b/%b required 0/0", imem_req, f_valid); end
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b1;
    imem_ack = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h3000 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL midwait_release: got %h/%b required 00003000/1", imem_addr, imem_req); end
    advance();
    imem_ack = 1'b1;
    #1;
    checks++; if (f_valid !== 1'b1 || f_pc !== 32'h3000) begin errors++; $display("[TB] FAIL midwait_fetch: got %b/%h required 1/00003000", f_valid, f_pc); end
    advance();
  endtask

  task automatic test_random();
    bit          tk, expDeliver, expAdel;
    logic [31:0] tg, rDpc, rJrt;
    int          kind;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 9));
      rDpc = $urandom & 32'hFFFF_FFFC;
      rJrt = $urandom;
      if ($urandom_range(0, 3) != 0) rJrt[1:0] = 2'b00;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6,
            kind == 1 || kind == 4, $urandom_range(0, 1) == 1,
            kind == 2 || kind == 4, kind == 3,
            rDpc, 16'($urandom), 26'($urandom), rJrt);
      #1;
      model_target(tk, tg);
      expDeliver = model_deliver();
      expAdel    = tk && !stall && (tg[1:0] != 2'b00);
      checks++; if (imem_req !== !mParked) begin errors++; $display("[TB] FAIL rnd_req@%0d: got %b required %b", n, imem_req, !mParked); end
      checks++; if (f_valid !== expDeliver) begin errors++; $display("[TB] FAIL rnd_fvalid@%0d: got %b required %b", n, f_valid, expDeliver); end
      checks++; if (adel !== expAdel) begin errors++; $display("[TB] FAIL rnd_adel@%0d: got %b required %b", n, adel, expAdel); end
      if (!mParked) begin
        checks++; if (imem_addr !== mPc) begin errors++; $display("[TB] FAIL rnd_addr@%0d: got %h required %h", n, imem_addr, mPc); end
      end
      if (expDeliver) begin
        checks++; if (f_pc !== mPc) begin errors++; $display("[TB] FAIL rnd_fpc@%0d: got %h required %h", n, f_pc, mPc); end
      end
      advance();
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    model_reset();
    test_reset();
    test_sequential();
    test_branch(1'b1);
    test_branch(1'b0);
    test_wait_pending();
    test_back_to_back();
    test_stall_hold();
    test_jr_misaligned();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 SHALL have parameter ALIGN_CHECK, default 1; when 1, misaligned redirect targets are flagged.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard stall from D; hold the current F instruction.
REQ-006 br_en  input  1  conditional branch instruction present in D.
REQ-007 cmp_cond  input  1  branch-taken result from the D-stage comparator.
REQ-008 j_en  input  1  j/jal in D.
REQ-009 jr_en  input  1  jr/jalr in D.
REQ-010 d_pc  input  32  PC of the D-stage instruction.
REQ-011 imm16  input  16  branch offset field of the D instruction.
REQ-012 index26  input  26  jump index field of the D instruction.
REQ-013 jr_target  input  32  forwarded register value for jr.
REQ-014 imem_req  output  1  fetch request to instruction memory.
REQ-015 imem_addr  output  32  fetch address; valid while imem_req=1.
REQ-016 imem_ack  input  1  instruction memory returns data this cycle.
REQ-017 f_pc  output  32  PC of the instruction delivered to the F/D register.
REQ-018 f_valid  output  1  F/D register load enable (instruction delivered).
REQ-019 adel  output  1  pulse: redirect target misaligned (ALIGN_CHECK=1).

Function
REQ-020 Redirect target SHALL be: branch -> d_pc+4+(sign_ext(imm16)<<2); j -> {d_pc[31:28], index26, 2'b00}; jr -> jr_target; priority jr > j > branch.
REQ-021 A redirect SHALL be taken only when stall=0 and (jr_en | j_en | (br_en & cmp_cond)); br_en with cmp_cond=0 SHALL NOT redirect.
REQ-022 Delay-slot semantics: the instruction at d_pc+4 SHALL always be fetched and delivered; the redirect target SHALL be the address after it.
REQ-023 FSM states: REQ (imem_req=1, address = pc_r), WAIT (imem_req=1, address held until ack), HOLD (ack received under stall, instruction parked).
REQ-024 REQ/WAIT with imem_ack=1 and stall=0 -> f_valid=1, f_pc=pc_r, pc_r <= next PC, next state REQ.
REQ-025 imem_ack=1 while stall=1 -> f_valid=0, next state HOLD; HOLD -> REQ-equivalent delivery on the first cycle stall=0.
REQ-026 REQ/WAIT with imem_ack=0 -> state WAIT; imem_addr SHALL NOT change while waiting.
REQ-027 Next PC SHALL be pc_r+4 unless a redirect is pending, then the redirect target.
REQ-028 A redirect arriving while no delivery occurs SHALL be latched in a one-entry pending register (pend_valid, pend_target) and applied at the next delivery; a later redirect overwrites an un-applied one.
REQ-029 Redirect and delivery in the same cycle SHALL use the redirect target directly, bypassing the pending register.
REQ-030 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-031 adel SHALL pulse one cycle when an accepted redirect target has bits[1:0]!=0; the target is still used unchanged.
REQ-032 f_valid SHALL be a single-cycle pulse per delivered instruction; never asserted in HOLD while stall=1.

Reset
REQ-033 While reset=0: pc_r=RESET_PC, state=REQ, pend_valid=0, f_valid=0, adel=0, f_pc=RESET_PC.
REQ-034 imem_req SHALL be 0 during reset and 1 on the first cycle after reset deasserts.
REQ-035 Reset asserted mid-WAIT SHALL abandon the outstanding fetch; an ack in the first cycle after release SHALL be ignored unless imem_req was high that cycle.

Structure
REQ-036 FSM state encodings, RESET_PC default and redirect-type codes SHALL reside in the shared head package with the CMP opcodes.
REQ-037 Target computation SHALL be one combinational sub-module, npc_calc; the FSM and pending register stay in branch_pc_unit.

Verification
REQ-038 Reset release, imem_ack=1 each cycle -> imem_addr 0x3000, 0x3004, 0x3008; f_valid high each cycle.
REQ-039 br_en=1, cmp_cond=1, d_pc=0x3000, imm16=0x0003, no stall -> delay slot 0x3004 delivered, next fetch 0x3010.
REQ-040 br_en=1, cmp_cond=0 -> fetch sequence continues 0x3008; no redirect.
REQ-041 imem_ack low 3 cycles -> imem_addr stable, f_valid=0; j to index26=0x0000C40 arriving meanwhile -> pending; after ack, next fetch 0x0000_3100.
REQ-042 stall=1 during ack -> HOLD, f_valid=0 until stall=0, then one f_valid pulse with the parked f_pc.
REQ-043 jr_target=0x0000_3002 -> adel pulses once; next fetch 0x0000_3002; reset mid-WAIT -> imem_addr 0x3000 after release.
